// File: rtl/serial_2scomp_rx.sv
// Bit-serial two's-complement receiver: negates an LSB-first frame on the fly
// with a copy-then-invert Mealy machine and deserializes the result.
module serial_2scomp_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    output logic             ovf,
    output logic             busy,
    output logic             abort_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        INV
    } state_t;

    state_t           state;
    state_t           state_next;
    state_t           eval_state;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    eval_count;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_val;
    logic             frame_start;
    logic             restart;
    logic             accept;
    logic             last_bit;
    logic             ovf_hit;

    // A start-qualified bit is always evaluated as bit 0 of a fresh frame,
    // even when it lands in the middle of another one.
    always_comb begin
        frame_start   = start && bit_valid;
        restart       = frame_start && (state != IDLE);
        accept        = bit_valid && ((state != IDLE) || start);
        eval_state    = frame_start ? IDLE : state;
        eval_count    = frame_start ? '0 : count;
        ser_out       = (eval_state == INV) ? ~bit_in : bit_in;
        ser_out_valid = accept;
        last_bit      = accept && (eval_count == LAST_IDX);
        ovf_hit       = last_bit && (eval_state != INV) && bit_in;
        shift_val     = {ser_out, shreg[WIDTH-1:1]};

        state_next = state;
        count_next = count;
        if (accept) begin
            if (last_bit) begin
                state_next = IDLE;
                count_next = '0;
            end else begin
                count_next = eval_count + CW'(1);
                if ((eval_state == INV) || bit_in) begin
                    state_next = INV;
                end else begin
                    state_next = COPY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            busy  <= (state_next != IDLE);
        end
    end

    // The completed word is captured from the shift value so that the last
    // Mealy bit lands in the MSB in the same cycle it is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            out_valid <= last_bit;
            abort_err <= restart;
            if (accept) begin
                shreg <= shift_val;
            end
            if (last_bit) begin
                out_word <= shift_val;
                ovf      <= ovf_hit;
            end
        end
    end

endmodule

// File: tb/tb_serial_2scomp_rx.sv
// Self-checking bench for serial_2scomp_rx: directed scenarios plus a random
// stream, checked against an arithmetic negation model.
module tb_serial_2scomp_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bit_valid = 1'b0;
    logic         bit_in = 1'b0;
    logic         ser_out;
    logic         ser_out_valid;
    logic [W-1:0] out_word;
    logic         out_valid;
    logic         ovf;
    logic         busy;
    logic         abort_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: frame membership, bits collected so far, and the
    // arithmetic negation of that prefix.
    logic         in_frame;
    int           nbits;
    logic [W-1:0] prefix;
    logic [W-1:0] negv;
    logic         exp_sov, exp_ser;
    logic         exp_ov, exp_ovf, exp_busy, exp_abort;
    logic [W-1:0] exp_word;
    logic         nxt_ov, nxt_ovf, nxt_busy, nxt_abort;
    logic [W-1:0] nxt_word;

    serial_2scomp_rx #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bit_valid(bit_valid),
        .bit_in(bit_in),
        .ser_out(ser_out),
        .ser_out_valid(ser_out_valid),
        .out_word(out_word),
        .out_valid(out_valid),
        .ovf(ovf),
        .busy(busy),
        .abort_err(abort_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        in_frame  = 1'b0;
        nbits     = 0;
        prefix    = '0;
        exp_sov   = 1'b0;
        exp_ser   = 1'b0;
        exp_ov    = 1'b0;
        exp_ovf   = 1'b0;
        exp_busy  = 1'b0;
        exp_abort = 1'b0;
        exp_word  = '0;
        nxt_ov    = 1'b0;
        nxt_ovf   = 1'b0;
        nxt_busy  = 1'b0;
        nxt_abort = 1'b0;
        nxt_word  = '0;
    endtask

    // Drive one cycle of inputs at the falling edge and update the model.
    task automatic step(input logic s, input logic v, input logic b);
        @(negedge clk);
        cyc++;
        exp_ov    = nxt_ov;
        exp_word  = nxt_word;
        exp_ovf   = nxt_ovf;
        exp_busy  = nxt_busy;
        exp_abort = nxt_abort;
        start     = s;
        bit_valid = v;
        bit_in    = b;
        #1;
        nxt_ov    = 1'b0;
        nxt_abort = 1'b0;
        exp_sov   = 1'b0;
        exp_ser   = 1'b0;
        if (v && s) begin
            if (in_frame) nxt_abort = 1'b1;
            in_frame = 1'b1;
            nbits    = 0;
            prefix   = '0;
        end
        if (v && in_frame) begin
            prefix[nbits] = b;
            negv    = -prefix;
            exp_ser = negv[nbits];
            exp_sov = 1'b1;
            nbits++;
            if (nbits == W) begin
                nxt_ov   = 1'b1;
                nxt_word = negv;
                nxt_ovf  = (prefix == (1 << (W - 1)));
                in_frame = 1'b0;
                nbits    = 0;
            end
        end
        nxt_busy = in_frame;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (out_word !== '0) begin n_err++; $display("[TB] FAIL reset_out_word got %h want 0", out_word); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (abort_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_abort_err got %b want 0", abort_err); end
        n_cmp++; if (ser_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_idle_no_start got %b want 0", ser_out_valid); end
        bit_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] frames [3] = '{4'b1010, 4'b0000, 4'b1000};
        logic [W-1:0] words  [3] = '{4'b0110, 4'b0000, 4'b1000};
        logic         ovfs   [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] f;
        for (int k = 0; k < 3; k++) begin
            f = frames[k];
            for (int i = 0; i <= W; i++) begin
                if (i < W) step(i == 0, 1'b1, f[i]);
                else step(1'b0, 1'b0, 1'b0);
                n_cmp++;
                if ({ser_out_valid, out_valid, busy, abort_err} !== {exp_sov, exp_ov, exp_busy, exp_abort}) begin
                    n_err++;
                    $display("[TB] FAIL directed_flags f%0d b%0d got %b want %b", k, i,
                             {ser_out_valid, out_valid, busy, abort_err}, {exp_sov, exp_ov, exp_busy, exp_abort});
                end
                if (exp_sov) begin
                    n_cmp++;
                    if (ser_out !== exp_ser) begin n_err++; $display("[TB] FAIL directed_ser f%0d b%0d got %b want %b", k, i, ser_out, exp_ser); end
                end
            end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL directed_valid f%0d got %b want 1", k, out_valid); end
            n_cmp++; if (out_word !== words[k]) begin n_err++; $display("[TB] FAIL directed_word f%0d got %b want %b", k, out_word, words[k]); end
            n_cmp++; if (ovf !== ovfs[k]) begin n_err++; $display("[TB] FAIL directed_ovf f%0d got %b want %b", k, ovf, ovfs[k]); end
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] f = 4'b0001;
        for (int i = 0; i < W; i++) begin
            step(i == 0, 1'b1, f[i]);
            n_cmp++; if (ser_out !== exp_ser) begin n_err++; $display("[TB] FAIL gaps_ser b%0d got %b want %b", i, ser_out, exp_ser); end
            if (i < W - 1) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                    n_cmp++;
                    if ({busy, out_valid, ser_out_valid} !== 3'b100) begin
                        n_err++;
                        $display("[TB] FAIL gaps_hold b%0d g%0d busy/ov/sov got %b want 100", i, g, {busy, out_valid, ser_out_valid});
                    end
                end
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL gaps_valid got %b want 1", out_valid); end
        n_cmp++; if (out_word !== 4'b1111) begin n_err++; $display("[TB] FAIL gaps_word got %b want 1111", out_word); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL gaps_busy_end got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] stream = {4'b0111, 4'b0001};
        int             pulse_cyc [$];
        logic [W-1:0]   pulse_word [$];
        for (int i = 0; i < 2 * W + 2; i++) begin
            if (i < 2 * W) step((i % W) == 0, 1'b1, stream[i]);
            else step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({ser_out_valid, out_valid, busy} !== {exp_sov, exp_ov, exp_busy}) begin
                n_err++;
                $display("[TB] FAIL b2b_flags c%0d got %b want %b", i, {ser_out_valid, out_valid, busy}, {exp_sov, exp_ov, exp_busy});
            end
            if (out_valid === 1'b1) begin
                pulse_cyc.push_back(cyc);
                pulse_word.push_back(out_word);
            end
        end
        n_cmp++;
        if (pulse_cyc.size() != 2) begin
            n_err++;
            $display("[TB] FAIL b2b_pulse_count got %0d want 2", pulse_cyc.size());
        end else begin
            n_cmp++; if (pulse_cyc[1] - pulse_cyc[0] != W) begin n_err++; $display("[TB] FAIL b2b_spacing got %0d want %0d", pulse_cyc[1] - pulse_cyc[0], W); end
            n_cmp++; if (pulse_word[0] !== 4'b1111) begin n_err++; $display("[TB] FAIL b2b_word0 got %b want 1111", pulse_word[0]); end
            n_cmp++; if (pulse_word[1] !== 4'b1001) begin n_err++; $display("[TB] FAIL b2b_word1 got %b want 1001", pulse_word[1]); end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] f = 4'b0011;
        int           pulses = 0;
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= W; i++) begin
            if (i < W) step(i == 0, 1'b1, f[i]);
            else step(1'b0, 1'b0, 1'b0);
            if (out_valid === 1'b1) pulses++;
            n_cmp++;
            if (abort_err !== (i == 1)) begin
                n_err++;
                $display("[TB] FAIL abort_pulse b%0d got %b want %b", i, abort_err, (i == 1));
            end
            n_cmp++;
            if (ser_out_valid && (ser_out !== exp_ser)) begin
                n_err++;
                $display("[TB] FAIL abort_ser b%0d got %b want %b", i, ser_out, exp_ser);
            end
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("[TB] FAIL abort_valid_count got %0d want 1", pulses); end
        n_cmp++; if (out_word !== 4'b1101) begin n_err++; $display("[TB] FAIL abort_word got %b want 1101", out_word); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(i == 0, 1'b1, 1'($urandom_range(0, 1)));
        @(posedge clk);
        #2;
        start = 1'b0;
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_word, out_valid, ovf, busy, abort_err} !== '0) begin
            n_err++;
            $display("[TB] FAIL rstmid_outputs got %b want 0", {out_word, out_valid, ovf, busy, abort_err});
        end
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            n_cmp++;
            if ({ser_out_valid, out_valid, busy} !== 3'b000) begin
                n_err++;
                $display("[TB] FAIL rstmid_ignore c%0d sov/ov/busy got %b want 000", i, {ser_out_valid, out_valid, busy});
            end
        end
    endtask

    task automatic test_random();
        logic s, v;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = in_frame ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            step(s, v, 1'($urandom_range(0, 1)));
            n_cmp++;
            if ({ser_out_valid, out_valid, busy, abort_err} !== {exp_sov, exp_ov, exp_busy, exp_abort}) begin
                n_err++;
                $display("[TB] FAIL random_flags c%0d got %b want %b", i,
                         {ser_out_valid, out_valid, busy, abort_err}, {exp_sov, exp_ov, exp_busy, exp_abort});
            end
            if (exp_sov) begin
                n_cmp++;
                if (ser_out !== exp_ser) begin n_err++; $display("[TB] FAIL random_ser c%0d got %b want %b", i, ser_out, exp_ser); end
            end
            n_cmp++;
            if ({out_word, ovf} !== {exp_word, exp_ovf}) begin
                n_err++;
                $display("[TB] FAIL random_word c%0d got %b/%b want %b/%b", i, out_word, ovf, exp_word, exp_ovf);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_2scomp_rx.md
Name: serial_2scomp_rx

Overview:
- Receiving end of the bit-serial two's-complement path.
- Accepts an LSB-first serial stream of WIDTH-bit frames and negates it on the fly with a Mealy machine: copy bits up to and including the first 1, invert every bit after it.
- Deserializes the result into a parallel word with a one-cycle valid strobe.
- Sits between a serial link/shifter and parallel consumers; also exposes the per-bit Mealy output.

Parameters:
WIDTH, 4, frame length in bits (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start; qualifies the first bit of a frame together with bit_valid
bit_valid  input  1  bit_in carries a valid serial bit this cycle
bit_in  input  1  serial data, LSB first
ser_out  output  1  combinational Mealy output bit for the current accepted bit
ser_out_valid  output  1  combinational; high when a bit is accepted this cycle
out_word  output  WIDTH  negated frame, registered; holds until the next completion
out_valid  output  1  one-cycle pulse, the cycle after the last bit is accepted
ovf  output  1  registered with out_word; 1 when the input frame was the most-negative value (1 followed by WIDTH-1 zeros)
busy  output  1  registered; 1 while a frame is in progress (state != IDLE)
abort_err  output  1  one-cycle registered pulse when start re-arrives mid-frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit count=0, shift register=0, out_word=0, out_valid=0, ovf=0, busy=0, abort_err=0.
- States:
  - IDLE: no frame in progress.
  - COPY: frame active, no 1 seen yet.
  - INV: frame active, a 1 has been seen.
- Accept rule:
  - A bit is accepted when bit_valid=1 and either state!=IDLE, or state=IDLE and start=1.
  - In IDLE, bit_valid without start is ignored.
  - bit_valid=0 mid-frame holds all state; gaps of any length are allowed.
- Mealy output:
  - In IDLE(+start) or COPY: ser_out=bit_in.
  - In INV: ser_out=~bit_in.
  - ser_out_valid equals accept.
- Transitions on accept:
  - IDLE/COPY with bit_in=1 -> INV.
  - IDLE/COPY with bit_in=0 -> COPY.
  - INV -> INV.
  - On the WIDTH-th accepted bit -> IDLE regardless.
- Shift register: on accept, shreg <= {ser_out, shreg[WIDTH-1:1]}. The count increments and wraps to 0 at frame end.
- Completion (WIDTH-th bit accepted in cycle N):
  - At N+1: out_word = {ser_out, shreg[WIDTH-1:1]} as of cycle N, out_valid=1.
  - ovf=1 iff the state was COPY/IDLE at the last bit and bit_in=1, i.e. the input was 1 followed by WIDTH-1 zeros; the output then equals the input.
  - An all-zero input gives out_word=0 and ovf=0.
- Latency: out_valid one cycle after the last bit.
- Back-to-back: start+bit_valid at N+1 begins a new frame. It coexists with the out_valid pulse of the previous frame with no bubble.
- start mid-frame (state!=IDLE, start=1, bit_valid=1):
  - Discard the partial frame; no out_valid.
  - abort_err pulses next cycle.
  - The current bit is treated as bit 0 of a new frame, evaluated as from IDLE.
- start with bit_valid=0 is ignored in every state.
- Reset mid-frame: partial frame lost, no out_valid; out_word returns to 0.
- Arithmetic: modulo 2^WIDTH negation; no width growth.

Test Plan:
- Frame 1010 (bits 0,1,0,1), start on the first bit, no gaps -> ser_out sequence 0,1,1,0; out_valid one cycle after the 4th bit; out_word=0110, ovf=0.
- Frame 0000 -> out_word=0000, ovf=0. Frame 1000 (bits 0,0,0,1) -> out_word=1000, ovf=1.
- Frame 0001 with bit_valid low 3 cycles between each bit -> busy held high throughout; out_word=1111 only after the 4th bit; no early out_valid.
- Back-to-back 0001 then 0111 with start on consecutive frame boundaries -> out_valid pulses exactly 4 cycles apart; out_word=1111 then 1001.
- 2 bits of a frame, then start with bit_valid -> abort_err pulse; no out_valid for the partial frame. A fresh frame 0011 completes -> out_word=1101.
- rst_n low for 1 cycle after 3 bits -> all outputs 0, busy=0 immediately. bit_valid without start afterwards is ignored; no out_valid.
